six_bit_serial_subtractor: RTL and testbench

Bit-serial subtractor. Computes a - b - borrow_in one bit per clock, using a registered full-subtractor borrow chain.
Shifts out the difference LSB-first into a result register. Uses a valid/ready handshake on both the operand side and the result side.
Sits beside the parallel adder datapath as the area-lean inverse (subtraction) path for 6-bit arithmetic.

---
 rtl/six_bit_serial_subtractor.sv | 163 ++++++++++++++++
 tb/tb_six_bit_serial_subtractor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/six_bit_serial_subtractor.sv
// ---------------------------------------------------------------------------
// six_bit_serial_subtractor
//
// Bit-serial subtractor: computes (a - b - borrow_in) one bit per clock with
// a registered full-subtractor borrow chain. The difference is shifted into
// the result register LSB-first (each new bit enters at the MSB and the
// register shifts right), so after WIDTH steps the result is aligned.
// This is the low-area subtraction path that sits next to the parallel
// adder datapath.
//
// Optional feature macro: SIX_BIT_SUB_OVERFLOW_EN
//   When defined, the 'overflow' port is present and reports two's
//   complement overflow of the subtraction. When undefined, the port and
//   its logic are absent.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present on a/b/borrow_in
//   in_ready   out  block can accept operands (IDLE only)
//   a          in   minuend [WIDTH]
//   b          in   subtrahend [WIDTH]
//   borrow_in  in   borrow subtracted at bit 0
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   diff       out  (a - b - borrow_in) mod 2^WIDTH [WIDTH]
//   borrow_out out  1 iff a < b + borrow_in (unsigned)
//   overflow   out  signed overflow (SIX_BIT_SUB_OVERFLOW_EN only)
// ---------------------------------------------------------------------------
module six_bit_serial_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SIX_BIT_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_out_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    // Full-subtractor cell on the current LSBs of the shift registers.
    logic d_bit;
    logic br_next;

    always_comb begin
        d_bit   = a_sr_reg[0] ^ b_sr_reg[0] ^ br_reg;
        br_next = (~a_sr_reg[0] & b_sr_reg[0]) |
                  (~(a_sr_reg[0] ^ b_sr_reg[0]) & br_reg);
    end

`ifdef SIX_BIT_SUB_OVERFLOW_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg    <= 1'b0;
            b_msb_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && in_valid) begin
                a_msb_reg <= a[WIDTH-1];
                b_msb_reg <= b[WIDTH-1];
            end
            // The bit being shifted in on the final RUN edge is the
            // result's sign bit, so overflow is decided on that edge.
            if (state_reg == RUN && cnt_reg == LAST_BIT) begin
                overflow_reg <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
            end
        end
    end

    assign overflow = overflow_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            a_sr_reg       <= '0;
            b_sr_reg       <= '0;
            br_reg         <= 1'b0;
            cnt_reg        <= '0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_reg     <= a;
                        b_sr_reg     <= b;
                        br_reg       <= borrow_in;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    diff_reg <= {d_bit, diff_reg[WIDTH-1:1]};
                    a_sr_reg <= a_sr_reg >> 1;
                    b_sr_reg <= b_sr_reg >> 1;
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        borrow_out_reg <= br_next;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    // Results stay put until the consumer takes them;
                    // diff/borrow_out keep their value after leaving DONE.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_six_bit_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_six_bit_serial_subtractor
//
// Self-checking bench for six_bit_serial_subtractor: a table of operand
// records with hand-computed results, a scoreboard queue filled when an
// operation is accepted and drained when the result appears, plus directed
// sequences for backpressure, back-to-back issue and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_six_bit_serial_subtractor;

    localparam int WIDTH = 6;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SIX_BIT_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    six_bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SIX_BIT_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_bout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[11];
    vec_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counts rising edges until out_valid is seen high at a falling edge.
    task automatic count_until_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 50);
    endtask

    // Drives one operation, pushes its expectation, waits for and checks it.
    task automatic run_op(input vec_t v, input string tag);
        int   lat;
        int   guard;
        vec_t e;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a         = v.a;
        b         = v.b;
        borrow_in = v.bin;
        in_valid  = 1'b1;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        count_until_valid(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(WIDTH));
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_diff"}, 32'(diff), 32'(e.exp_diff));
            chk({tag, "_borrow_out"}, 32'(borrow_out), 32'(e.exp_bout));
`ifdef SIX_BIT_SUB_OVERFLOW_EN
            chk({tag, "_overflow"}, 32'(overflow), 32'(e.exp_ovf));
`endif
            $display("op a=%0d b=%0d bin=%0d -> diff=%0d borrow_out=%0d lat=%0d",
                     e.a, e.b, e.bin, diff, borrow_out, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        vec_t v;

        //            a   b  bin diff bout ovf
        vecs[0]  = '{6'd20, 6'd7,  1'b0, 6'd13, 1'b0, 1'b0};
        vecs[1]  = '{6'd5,  6'd9,  1'b0, 6'd60, 1'b1, 1'b0};
        vecs[2]  = '{6'd0,  6'd0,  1'b1, 6'd63, 1'b1, 1'b0};
        vecs[3]  = '{6'd63, 6'd1,  1'b0, 6'd62, 1'b0, 1'b0};
        vecs[4]  = '{6'd10, 6'd10, 1'b0, 6'd0,  1'b0, 1'b0};
        vecs[5]  = '{6'd32, 6'd1,  1'b0, 6'd31, 1'b0, 1'b1};
        vecs[6]  = '{6'd31, 6'd1,  1'b0, 6'd30, 1'b0, 1'b0};
        vecs[7]  = '{6'd0,  6'd63, 1'b0, 6'd1,  1'b1, 1'b0};
        vecs[8]  = '{6'd63, 6'd63, 1'b1, 6'd63, 1'b1, 1'b0};
        vecs[9]  = '{6'd1,  6'd2,  1'b1, 6'd62, 1'b1, 1'b0};
        vecs[10] = '{6'd31, 6'd32, 1'b0, 6'd63, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow_out", 32'(borrow_out), 32'd0);
`ifdef SIX_BIT_SUB_OVERFLOW_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold result with out_ready low, offer new operands
        @(negedge clk);
        out_ready = 1'b0;
        run_op(vecs[0], "bp");
        a         = 6'd1;
        b         = 6'd2;
        borrow_in = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'd13);
            chk("bp_borrow_out", 32'(borrow_out), 32'd0);
        end
        $display("backpressure held 4 cycles diff=%0d", diff);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_diff_kept", 32'(diff), 32'd13);
        @(negedge clk);
        chk("bp_no_accept", 32'(in_ready), 32'd1);

        // Back-to-back with in_valid and out_ready held high
        a         = 6'd63;
        b         = 6'd1;
        borrow_in = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        a = 6'd10;
        b = 6'd10;
        count_until_valid(lat);
        chk("b2b_first_latency", 32'(lat), 32'(WIDTH));
        chk("b2b_first_diff", 32'(diff), 32'd62);
        chk("b2b_first_borrow", 32'(borrow_out), 32'd0);
        $display("b2b first diff=%0d borrow_out=%0d lat=%0d", diff, borrow_out, lat);
        count_until_valid(lat);
        in_valid = 1'b0;
        chk("b2b_spacing", 32'(lat), 32'(WIDTH + 2));
        chk("b2b_second_diff", 32'(diff), 32'd0);
        chk("b2b_second_borrow", 32'(borrow_out), 32'd0);
        $display("b2b second diff=%0d borrow_out=%0d spacing=%0d", diff, borrow_out, lat);

        // Reset mid-operation (after 3 RUN cycles)
        @(negedge clk);
        @(negedge clk);
        chk("mid_idle_before", 32'(in_ready), 32'd1);
        a         = 6'd20;
        b         = 6'd7;
        borrow_in = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_borrow_out", 32'(borrow_out), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        $display("reset mid-op: out_valid=%0d diff=%0d in_ready=%0d", out_valid, diff, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{6'd1, 6'd1, 1'b0, 6'd0, 1'b0, 1'b0};
        run_op(v, "post_rst");

        if (sb_q.size() != 0) chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
